sv32_phys_mem_responder: RTL

SV32_PHYS_MEM_RESPONDER -- requirements
Module: sv32_phys_mem_responder

---
 rtl/sv32_phys_mem_responder_pkg.sv | 35 +++
 rtl/sv32_phys_mem_responder_bytelane_ram.sv | 47 ++++
 rtl/sv32_phys_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sv32_phys_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// sv32_phys_mem_responder_pkg
// Shared items for the SV32 physical memory responder: the responder FSM
// state type, the physical address width and the address range check.
// RAM depth and latency belong to the responder's parameters, not to this
// package.
// ---------------------------------------------------------------------------
package sv32_phys_mem_responder_pkg;

  // SV32 physical addresses are 34 bits wide.
  localparam int PHYS_ADDR_W = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // True when addr lies outside [base, base + 4*depthWords). The compare is
  // one bit wider than an address so that the end of the window cannot wrap.
  function automatic logic isOutOfRange(
    input logic [PHYS_ADDR_W-1:0] addr,
    input logic [PHYS_ADDR_W-1:0] base,
    input int                     depthWords
  );
    logic [PHYS_ADDR_W:0] w_addr;
    logic [PHYS_ADDR_W:0] w_lo;
    logic [PHYS_ADDR_W:0] w_hi;
    w_addr = {1'b0, addr};
    w_lo   = {1'b0, base};
    w_hi   = w_lo + ((PHYS_ADDR_W+1)'(depthWords) << 2);
    return (w_addr < w_lo) || (w_addr >= w_hi);
  endfunction

endpackage

// File: rtl/sv32_phys_mem_responder_bytelane_ram.sv
// ---------------------------------------------------------------------------
// sv32_bytelane_ram
// 32-bit wide RAM built from four byte lanes. Simple dual-port: one
// synchronous read port and one write port with a per-lane write enable.
// No reset, so contents survive a responder reset.
//
// Ports:
//   clk      clock
//   i_rdEn   capture the word at i_rdIdx into o_rdata on this edge
//   i_rdIdx  read word index
//   o_rdata  registered read data, held while i_rdEn is low
//   i_wrEn   per byte-lane write enables
//   i_wrIdx  write word index
//   i_wdata  write data
// ---------------------------------------------------------------------------
module sv32_bytelane_ram #(
  parameter  int DEPTH_WORDS = 4096,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_rdEn,
  input  logic [AW-1:0] i_rdIdx,
  output logic [31:0]   o_rdata,
  input  logic [3:0]    i_wrEn,
  input  logic [AW-1:0] i_wrIdx,
  input  logic [31:0]   i_wdata
);

  logic [3:0][7:0] r_mem [DEPTH_WORDS];
  logic [31:0]     r_q;

  // Lane-wise write and registered read; a read and write to the same word on
  // the same edge returns the old contents.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_wrEn[l]) begin
        r_mem[i_wrIdx][l] <= i_wdata[8*l +: 8];
      end
    end
    if (i_rdEn) begin
      r_q <= r_mem[i_rdIdx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sv32_phys_mem_responder.sv
// ---------------------------------------------------------------------------
// sv32_phys_mem_responder
// Valid/ready physical memory slave for an SV32 core. A request held on
// mem_valid is latched in IDLE, delayed WAIT_STATES cycles, and completed by
// a one-cycle mem_ready pulse in RESP. Writes commit at the end of RESP; the
// read data shown in RESP is the word content before any write.
//
// Build option: define SV32_PHYS_RESP_FAULT_EN to flag requests outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) with access_fault (no write, zero
// read data). Without it access_fault is 0 and addresses alias modulo the
// RAM size.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit RAM words (power of two)
//   BASE_ADDR    physical byte address of word 0
//   WAIT_STATES  extra cycles before ready (0..15)
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   mem_valid     request pending, held until ready
//   mem_ready     one-cycle completion pulse
//   mem_wstrb     byte write enables, 0 means read
//   mem_addr      34-bit physical byte address
//   mem_wdata     write data
//   mem_rdata     read data, held until the next completion
//   access_fault  pulse coincident with a faulting mem_ready
// ---------------------------------------------------------------------------
module sv32_phys_mem_responder
  import sv32_phys_mem_responder_pkg::*;
#(
  parameter int                     DEPTH_WORDS = 4096,
  parameter logic [PHYS_ADDR_W-1:0] BASE_ADDR   = 34'h0_8000_0000,
  parameter int                     WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [3:0]             mem_wstrb,
  input  logic [PHYS_ADDR_W-1:0] mem_addr,
  input  logic [31:0]            mem_wdata,
  output logic [31:0]            mem_rdata,
  output logic                   access_fault
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  resp_state_t            r_state;
  logic [3:0]             r_waitCnt;
  logic [PHYS_ADDR_W-1:0] r_addr;
  logic [3:0]             r_wstrb;
  logic [31:0]            r_wdata;
  logic                   r_ready;
  logic                   r_fault;
  logic [31:0]            r_rdata;

  logic [PHYS_ADDR_W-1:0] w_curAddr;
  logic [PHYS_ADDR_W-1:0] w_curOff;
  logic [PHYS_ADDR_W-1:0] w_wrOff;
  logic [AW-1:0]          w_curIdx;
  logic [AW-1:0]          w_wrIdx;
  logic                   w_curFault;
  logic                   w_enterResp;
  logic [3:0]             w_ramWrEn;
  logic [31:0]            w_ramQ;
  logic [31:0]            w_respData;

  // The request address is the live input in IDLE (WAIT_STATES=0 jumps to
  // RESP on the accepting edge) and the latched copy afterwards.
  assign w_curAddr = (r_state == IDLE) ? mem_addr : r_addr;
  assign w_curOff  = w_curAddr - BASE_ADDR;
  assign w_wrOff   = r_addr - BASE_ADDR;
  assign w_curIdx  = AW'(w_curOff >> 2);
  assign w_wrIdx   = AW'(w_wrOff >> 2);

`ifdef SV32_PHYS_RESP_FAULT_EN
  assign w_curFault = isOutOfRange(w_curAddr, BASE_ADDR, DEPTH_WORDS);
`else
  assign w_curFault = 1'b0;
`endif

  // The RAM read is launched on the edge entering RESP so its data is
  // available throughout the RESP cycle.
  assign w_enterResp = ((r_state == IDLE) && mem_valid && (WAIT_STATES == 0)) ||
                       ((r_state == WAIT) && mem_valid && (r_waitCnt == 4'd1));

  assign w_ramWrEn = ((r_state == RESP) && !r_fault) ? r_wstrb : 4'b0000;

  sv32_bytelane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_rdEn  (w_enterResp),
    .i_rdIdx (w_curIdx),
    .o_rdata (w_ramQ),
    .i_wrEn  (w_ramWrEn),
    .i_wrIdx (w_wrIdx),
    .i_wdata (r_wdata)
  );

  assign w_respData = r_fault ? 32'h0 : w_ramQ;

  // Responder FSM. mem_ready/access_fault are registered on the edge into
  // RESP; the RESP read data is captured into r_rdata so it stays visible
  // until the next completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_waitCnt <= 4'd0;
      r_addr    <= '0;
      r_wstrb   <= 4'b0000;
      r_wdata   <= 32'h0;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_ready <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_addr    <= mem_addr;
            r_wstrb   <= mem_wstrb;
            r_wdata   <= mem_wdata;
            r_waitCnt <= WAIT_INIT;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_fault <= w_curFault;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_valid) begin
            r_state   <= IDLE;
            r_waitCnt <= 4'd0;
          end else if (r_waitCnt == 4'd1) begin
            r_state   <= RESP;
            r_waitCnt <= 4'd0;
            r_ready   <= 1'b1;
            r_fault   <= w_curFault;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_rdata <= w_respData;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_ready    = r_ready;
  assign access_fault = r_fault;
  assign mem_rdata    = r_ready ? w_respData : r_rdata;

endmodule
